// File: rtl/c17_bist_pkg.sv
// Shared types and helpers for the c17 BIST sequencer.
// Holds the FSM encoding, default MISR constants and the MISR step function.
package c17_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_e;

    localparam int          C17_PAT_W     = 5;
    localparam int          PAT_COUNT     = 1 << C17_PAT_W;
    localparam logic [15:0] MISR_POLY_DEF = 16'h1021;
    localparam logic [15:0] MISR_SEED_DEF = 16'hFFFF;

    // Width-generic MISR step; operands are zero-extended to 64 bits by callers.
    function automatic logic [63:0] misr_step(
        input logic [63:0] sig,
        input logic [63:0] poly,
        input logic [63:0] din,
        input int unsigned w
    );
        logic [63:0] mask;
        logic [63:0] nxt;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        nxt  = (sig << 1) ^ (sig[6'(w - 1)] ? poly : 64'd0) ^ din;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/c17_bist_ctrl_misr.sv
// Multiple-input signature register used to compact the core response.
// load has priority over en; the value holds when neither is set.
module bist_misr
    import c17_bist_pkg::*;
#(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(MISR_POLY_DEF),
    parameter logic [MISR_W-1:0] MISR_SEED = MISR_W'(MISR_SEED_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [MISR_W-1:0] din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = MISR_SEED;
        end else if (en) begin
            sig_d = MISR_W'(misr_step(64'(sig_q), 64'(MISR_POLY),
                                      64'(din), MISR_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= MISR_SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST sequencer: walks every input vector of the c17 core, holds each
// for a settle time, folds the response into a MISR and flags pass/fail.
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int                PAT_W     = 5,
    parameter int                RSP_W     = 2,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(MISR_POLY_DEF),
    parameter logic [MISR_W-1:0] MISR_SEED = MISR_W'(MISR_SEED_DEF),
    parameter int                SETTLE    = 2,
    parameter logic [MISR_W-1:0] GOLDEN    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [PAT_W-1:0]  pat_o,
    input  logic [RSP_W-1:0]  resp_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam logic [7:0]       WAIT_INIT = 8'(SETTLE - 1);
    localparam logic [PAT_W-1:0] PAT_LAST  = '1;

    bist_state_e       state_q, state_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [7:0]        wait_q, wait_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              misr_load;
    logic              misr_en;
    logic [MISR_W-1:0] resp_ext;
    logic [MISR_W-1:0] sig_next;

    assign resp_ext = MISR_W'(resp_i);
    assign sig_next = MISR_W'(misr_step(64'(signature), 64'(MISR_POLY),
                                        64'(resp_ext), MISR_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            wait_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            wait_q  <= wait_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        wait_d  = wait_q;
        done_d  = done_q;
        pass_d  = pass_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    pat_d   = '0;
                    wait_d  = WAIT_INIT;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pat_d   = '0;
                end else if (wait_q == 8'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pat_d   = '0;
                end else if (pat_q == PAT_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (sig_next == GOLDEN);
                end else begin
                    state_d = ST_WAIT;
                    pat_d   = pat_q + 1'b1;
                    wait_d  = WAIT_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // An abort during CAPTURE leaves the partial signature untouched.
    always_comb begin
        busy      = (state_q == ST_WAIT) || (state_q == ST_CAPTURE);
        misr_load = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
        misr_en   = (state_q == ST_CAPTURE) && !abort;
    end

    bist_misr #(
        .MISR_W   (MISR_W),
        .MISR_POLY(MISR_POLY),
        .MISR_SEED(MISR_SEED)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .load(misr_load),
        .en  (misr_en),
        .din (resp_ext),
        .sig (signature)
    );

    assign pat_o = pat_q;
    assign done  = done_q;
    assign pass  = pass_q;

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Directed bench for c17_bist_ctrl with a c17 gate model on resp_i.
// GOLDEN is taken from an independent reference MISR run over the model.
module tb_c17_bist_ctrl;

    function automatic logic [1:0] c17(input logic [4:0] p, input bit sa0);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19, n22, n23;
        {n1, n2, n3, n6, n7} = p;
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        n22 = ~(n10 & n16);
        n23 = ~(n16 & n19);
        return {n22, n23 & ~sa0};
    endfunction

    function automatic logic [15:0] ref_sig(input bit sa0);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)
                ^ {14'd0, c17(5'(i), sa0)};
        end
        return s;
    endfunction

    localparam logic [15:0] REF_GOLDEN = ref_sig(1'b0);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  pat_o;
    logic [1:0]  resp_i;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    bit          stuck = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_n;
    int done_at;
    int seq_err;

    always #5 clk = ~clk;

    always_comb resp_i = c17(pat_o, stuck);

    c17_bist_ctrl #(
        .PAT_W    (5),
        .RSP_W    (2),
        .MISR_W   (16),
        .MISR_POLY(16'h1021),
        .MISR_SEED(16'hFFFF),
        .SETTLE   (2),
        .GOLDEN   (REF_GOLDEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pat_o    (pat_o),
        .resp_i   (resp_i),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .signature(signature)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Leaves the bench at the first negedge after start is sampled (cycle 1).
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded watch of one run; optionally pulses start at cycles 10 and 50.
    task automatic track(input int maxc, input bit inj);
        busy_n  = 0;
        done_at = 0;
        seq_err = 0;
        for (int c = 1; c <= maxc && done_at == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) begin
                busy_n++;
                if (pat_o != 5'((c - 1) / 3)) seq_err++;
            end
            if (done) done_at = c;
            start = inj && (c == 10 || c == 50);
        end
        start = 1'b0;
    endtask

    task automatic chk_run(input string tag, input logic [15:0] sig_exp,
                           input logic pass_exp);
        chk({tag, "_busy_len"}, 32'(busy_n), 32'd96);
        chk({tag, "_done_at"}, 32'(done_at), 32'd97);
        chk({tag, "_seq"}, 32'(seq_err), 32'd0);
        chk({tag, "_sig"}, 32'(signature), 32'(sig_exp));
        chk({tag, "_pass"}, 32'(pass), 32'(pass_exp));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_pat", 32'(pat_o), 32'd0);
        chk("rst_sig", 32'(signature), 32'hFFFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        rst = 1'b0;

        kick();
        track(150, 1'b0);
        chk_run("run1", REF_GOLDEN, 1'b1);
        repeat (5) @(negedge clk);
        chk("done_held", 32'(done), 32'd1);
        chk("pat_last", 32'(pat_o), 32'd31);

        stuck = 1'b1;
        kick();
        track(150, 1'b0);
        chk_run("sa0", ref_sig(1'b1), 1'b0);
        chk("sa0_differs", 32'(signature != REF_GOLDEN), 32'd1);
        stuck = 1'b0;

        kick();
        track(150, 1'b1);
        chk_run("start_busy", REF_GOLDEN, 1'b1);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done_clr", 32'(done), 32'd0);
        chk("abort_pass_clr", 32'(pass), 32'd0);
        chk("abort_done_sig", 32'(signature), 32'(REF_GOLDEN));

        kick();
        repeat (39) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pat", 32'(pat_o), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        kick();
        track(150, 1'b0);
        chk_run("after_abort", REF_GOLDEN, 1'b1);

        kick();
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_pat", 32'(pat_o), 32'd0);
        chk("mrst_sig", 32'(signature), 32'hFFFF);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        kick();
        track(150, 1'b0);
        chk_run("post_rst", REF_GOLDEN, 1'b1);
        kick();
        track(150, 1'b0);
        chk_run("rerun", REF_GOLDEN, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
